// File: rtl/cache_bank_port.sv
// Cache bank port: request FIFO, single-word SRAM sequencer, response return.
// Define WRITE_ACK_EN to make every write return an acknowledge packet.
module cache_bank_port #(
  parameter int NET_ADDR_W   = 16,
  parameter int BANK_ADDR_W  = 12,
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [NET_ADDR_W-1:0]  req_dest_addr,
  input  logic [NET_ADDR_W-1:0]  req_src_addr,
  input  logic                   req_read,
  input  logic                   req_write,
  input  logic [DATA_W-1:0]      req_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [NET_ADDR_W-1:0]  resp_dest_addr,
  output logic [NET_ADDR_W-1:0]  resp_src_addr,
  output logic                   resp_read,
  output logic                   resp_write,
  output logic [DATA_W-1:0]      resp_data,
  output logic [BANK_ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0]      cache_data_in,
  output logic                   mem_read,
  output logic                   mem_write,
  input  logic [DATA_W-1:0]      cache_data_out,
  output logic [7:0]             err_count
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  typedef struct packed {
    logic [NET_ADDR_W-1:0] dst;
    logic [NET_ADDR_W-1:0] src;
    logic                  rd;
    logic [DATA_W-1:0]     data;
  } ent_t;

  ent_t                   fifo_q [FIFO_DEPTH];
  ent_t                   head;
  logic [PTR_W-1:0]       wr_q, rd_q, wr_d, rd_d;
  logic                   ready_q;
  logic [1:0]             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NET_ADDR_W-1:0]  op_dst_q, op_src_q;
  logic                   op_rd_q;
  logic [BANK_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]      din_q;
  logic                   mrd_q, mwr_q;
  logic                   rv_q, rrd_q;
  logic [NET_ADDR_W-1:0]  rdst_q, rsrc_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [7:0]             err_q;
  logic                   legal, accept, push, pop, empty, full_d;

  assign legal  = req_read ^ req_write;
  assign accept = req_valid & ready_q;
  assign push   = accept & legal;
  assign empty  = (wr_q == rd_q);
  assign pop    = (state_q == S_IDLE) & ~empty;
  assign wr_d   = wr_q + PTR_W'(push);
  assign rd_d   = rd_q + PTR_W'(pop);
  assign head   = fifo_q[rd_q[IDX_W-1:0]];
  // Ready is registered from next-state pointers: no path from req_valid.
  assign full_d = (wr_d[PTR_W-1] != rd_d[PTR_W-1]) &&
                  (wr_d[IDX_W-1:0] == rd_d[IDX_W-1:0]);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_q[IDX_W-1:0]] <= '{req_dest_addr, req_src_addr,
                                   req_read, req_data};
    end
  end

`ifdef WRITE_ACK_EN
  logic rwr_q;
  assign resp_write = rwr_q;
`else
  assign resp_write = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      ready_q  <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_dst_q <= '0;
      op_src_q <= '0;
      op_rd_q  <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      rv_q     <= 1'b0;
      rrd_q    <= 1'b0;
      rdst_q   <= '0;
      rsrc_q   <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
`ifdef WRITE_ACK_EN
      rwr_q    <= 1'b0;
`endif
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ready_q <= ~full_d;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      if (accept && !legal && err_q != 8'hFF) begin
        err_q <= err_q + 8'd1;
      end
      unique case (1'b1)
        state_q == S_IDLE: begin
          if (!empty) begin
            op_dst_q <= head.dst;
            op_src_q <= head.src;
            op_rd_q  <= head.rd;
            addr_q   <= head.dst[BANK_ADDR_W-1:0];
            din_q    <= head.data;
            mrd_q    <= head.rd;
            mwr_q    <= ~head.rd;
            state_q  <= S_ACCESS;
          end
        end
        state_q == S_ACCESS: begin
          if (op_rd_q) begin
            cnt_q   <= CNT_W'(READ_LATENCY);
            state_q <= S_WAIT;
          end else begin
`ifdef WRITE_ACK_EN
            rdst_q  <= op_src_q;
            rsrc_q  <= op_dst_q;
            rrd_q   <= 1'b0;
            rwr_q   <= 1'b1;
            rdata_q <= din_q;
            rv_q    <= 1'b1;
            state_q <= S_RESP;
`else
            state_q <= S_IDLE;
`endif
          end
        end
        state_q == S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rdst_q  <= op_src_q;
            rsrc_q  <= op_dst_q;
            rrd_q   <= 1'b1;
            rdata_q <= cache_data_out;
            rv_q    <= 1'b1;
            state_q <= S_RESP;
`ifdef WRITE_ACK_EN
            rwr_q   <= 1'b0;
`endif
          end
        end
        state_q == S_RESP: begin
          if (resp_ready) begin
            rv_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = ready_q;
  assign resp_valid     = rv_q;
  assign resp_dest_addr = rdst_q;
  assign resp_src_addr  = rsrc_q;
  assign resp_read      = rrd_q;
  assign resp_data      = rdata_q;
  assign cache_addr     = addr_q;
  assign cache_data_in  = din_q;
  assign mem_read       = mrd_q;
  assign mem_write      = mwr_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_cache_bank_port.sv
// Bench for cache_bank_port: transaction-level model plus SRAM with delayed read.
// Honours WRITE_ACK_EN and the RL parameter (read latency).
module tb_cache_bank_port #(
  parameter int RL = 1
);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_read, req_write;
  logic [15:0] req_dest_addr, req_src_addr;
  logic [31:0] req_data;
  logic        resp_valid, resp_ready, resp_read, resp_write;
  logic [15:0] resp_dest_addr, resp_src_addr;
  logic [31:0] resp_data;
  logic [11:0] cache_addr;
  logic [31:0] cache_data_in, cache_data_out;
  logic        mem_read, mem_write;
  logic [7:0]  err_count;

  logic        rnd_bp = 1'b0;
  logic        rr_rand = 1'b1;
  logic        rr_dir;
  assign resp_ready = rnd_bp ? rr_rand : rr_dir;

  always #5 clk = ~clk;

  cache_bank_port #(
    .NET_ADDR_W(16), .BANK_ADDR_W(12), .DATA_W(32),
    .FIFO_DEPTH(4), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest_addr(req_dest_addr), .req_src_addr(req_src_addr),
    .req_read(req_read), .req_write(req_write), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_dest_addr(resp_dest_addr), .resp_src_addr(resp_src_addr),
    .resp_read(resp_read), .resp_write(resp_write), .resp_data(resp_data),
    .cache_addr(cache_addr), .cache_data_in(cache_data_in),
    .mem_read(mem_read), .mem_write(mem_write),
    .cache_data_out(cache_data_out), .err_count(err_count)
  );

`ifdef WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // SRAM: writes land at the edge; read data appears RL cycles after strobe.
  logic [31:0] sram [4096];
  logic [31:0] pipe [RL];
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr;
  logic [31:0] poke_data;
  assign cache_data_out = pipe[RL-1];

  always @(posedge clk) begin
    if (poke_en) sram[poke_addr] <= poke_data;
    if (mem_write) sram[cache_addr] <= cache_data_in;
    pipe[0] <= mem_read ? sram[cache_addr] : $urandom;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    rr_rand <= ($urandom_range(0, 3) != 0);
  end

  typedef struct {
    logic [15:0] dst, src;
    logic        rd, wr;
    logic [31:0] data;
  } resp_t;
  typedef struct {
    logic        rd;
    logic [11:0] addr;
    logic [31:0] data;
  } acc_t;

  resp_t       exp_resp [$];
  acc_t        exp_acc [$];
  logic [31:0] shadow [4096];
  int          err_m = 0;
  bit          resync = 1'b0;
  int          cyc = 0;

  // Transaction model: ops execute in acceptance order, so memory contents
  // seen by a read equal all earlier accepted writes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      exp_resp.delete();
      exp_acc.delete();
      err_m = 0;
      resync = 1'b1;
    end else begin
      if (resync) begin
        shadow = sram;
        resync = 1'b0;
      end
      if (poke_en) shadow[poke_addr] = poke_data;
      if (resp_valid && resp_ready && exp_resp.size() > 0)
        void'(exp_resp.pop_front());
      if (req_valid && req_ready) begin
        if (req_read ^ req_write) begin
          exp_acc.push_back('{req_read, req_dest_addr[11:0], req_data});
          if (req_read) begin
            exp_resp.push_back('{req_src_addr, req_dest_addr, 1'b1, 1'b0,
                                 shadow[req_dest_addr[11:0]]});
          end else begin
            shadow[req_dest_addr[11:0]] = req_data;
            if (ACK)
              exp_resp.push_back('{req_src_addr, req_dest_addr, 1'b0, 1'b1,
                                   req_data});
          end
        end else if (err_m < 255) begin
          err_m = err_m + 1;
        end
      end
    end
  end

  bit          chk_en = 1'b0;
  bit          rv_prev = 1'b0;
  int          strobe_cyc = 0;
  bit          strobe_wr = 1'b0;
  int          rv_cyc = 0;
  int          rv_cnt = 0;
  logic [15:0] l_dst, l_src;
  logic        l_rd;
  logic [31:0] l_data;

  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_read || mem_write) begin
        strobe_cyc = cyc;
        strobe_wr = mem_write;
        if (exp_acc.size() == 0) begin
          chk(1'b0, "unexpected_strobe", {mem_read, mem_write}, 0);
        end else begin
          acc_t a;
          a = exp_acc.pop_front();
          chk(mem_read == a.rd && mem_write == !a.rd &&
              cache_addr == a.addr && (a.rd || cache_data_in == a.data),
              "strobe", {mem_read, mem_write, cache_addr, cache_data_in},
              {a.rd, !a.rd, a.addr, a.data});
        end
      end
      if (resp_valid) begin
        if (!rv_prev) begin
          rv_cyc = cyc;
          rv_cnt++;
          l_dst = resp_dest_addr;
          l_src = resp_src_addr;
          l_rd = resp_read;
          l_data = resp_data;
        end
        if (exp_resp.size() == 0) begin
          chk(1'b0, "unexpected_resp", {resp_dest_addr, resp_data}, 0);
        end else begin
          chk(resp_dest_addr == exp_resp[0].dst &&
              resp_src_addr == exp_resp[0].src &&
              resp_read == exp_resp[0].rd &&
              resp_write == exp_resp[0].wr &&
              resp_data == exp_resp[0].data, "resp",
              {resp_dest_addr, resp_src_addr, resp_read, resp_write, resp_data},
              {exp_resp[0].dst, exp_resp[0].src, exp_resp[0].rd,
               exp_resp[0].wr, exp_resp[0].data});
        end
      end
      rv_prev = resp_valid;
      chk(err_count == err_m[7:0], "err_count", err_count, err_m);
    end
  end

  int acc_cyc = 0;

  task automatic set_req(input logic [15:0] d, input logic [15:0] s,
                         input logic r, input logic w, input logic [31:0] x);
    req_valid = 1'b1;
    req_dest_addr = d;
    req_src_addr = s;
    req_read = r;
    req_write = w;
    req_data = x;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] s,
                      input logic r, input logic w, input logic [31:0] x);
    int t;
    t = 0;
    set_req(d, s, r, w, x);
    while (!req_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) begin
      chk(1'b0, "req_timeout", t, 300);
      req_valid = 1'b0;
    end else begin
      acc_cyc = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain(input int n);
    int t;
    t = 0;
    while ((exp_resp.size() != 0 || exp_acc.size() != 0) && t < n) begin
      @(posedge clk); #1;
      t++;
    end
    chk(exp_resp.size() == 0 && exp_acc.size() == 0, "drain",
        {exp_resp.size(), exp_acc.size()}, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    poke_en = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  initial begin
    int n0;
    int t;
    rst_n = 1'b0;
    rr_dir = 1'b1;
    req_valid = 1'b0;
    req_read = 1'b0;
    req_write = 1'b0;
    req_dest_addr = '0;
    req_src_addr = '0;
    req_data = '0;
    poke_addr = '0;
    poke_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(req_ready == 1'b0, "rst_req_ready", req_ready, 0);
    chk({resp_valid, mem_read, mem_write, err_count, cache_addr, resp_data} == 0,
        "rst_outputs",
        {resp_valid, mem_read, mem_write, err_count, cache_addr, resp_data}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk(req_ready == 1'b1, "ready_after_rst", req_ready, 1);
    chk_en = 1'b1;

    // Single read
    poke(12'h012, 32'hDEADBEEF);
    send(16'h3012, 16'h5000, 1'b1, 1'b0, 32'h0);
    drain(60);
    chk(strobe_cyc - acc_cyc == 2 && !strobe_wr, "rd_strobe_cycle",
        strobe_cyc - acc_cyc, 2);
    chk(rv_cyc - acc_cyc == 3 + RL, "rd_resp_cycle", rv_cyc - acc_cyc, 3 + RL);
    chk(l_data == 32'hDEADBEEF, "rd_data", l_data, 32'hDEADBEEF);
    chk(l_dst == 16'h5000 && l_src == 16'h3012 && l_rd == 1'b1, "rd_addrs",
        {l_dst, l_src, l_rd}, {16'h5000, 16'h3012, 1'b1});

    // Write then read back
    n0 = rv_cnt;
    send(16'h3034, 16'h7001, 1'b0, 1'b1, 32'h0000A5A5);
    drain(60);
    chk(strobe_cyc - acc_cyc == 2 && strobe_wr, "wr_strobe_cycle",
        strobe_cyc - acc_cyc, 2);
    chk(rv_cnt - n0 == int'(ACK), "wr_ack_count", rv_cnt - n0, ACK);
    if (ACK) chk(rv_cyc - acc_cyc == 3, "wr_ack_cycle", rv_cyc - acc_cyc, 3);
    send(16'h3034, 16'h7001, 1'b1, 1'b0, 32'h0);
    drain(60);
    chk(l_data == 32'h0000A5A5, "rd_after_wr", l_data, 32'h0000A5A5);

    // Illegal requests
    n0 = rv_cnt;
    send(16'h3040, 16'h5000, 1'b1, 1'b1, 32'h1);
    send(16'h3041, 16'h5000, 1'b0, 1'b0, 32'h2);
    repeat (10) @(posedge clk);
    #1;
    chk(err_count == 8'd2, "err_two", err_count, 2);
    chk(rv_cnt == n0, "illegal_no_resp", rv_cnt - n0, 0);
    for (int i = 0; i < 300; i++)
      send(16'h3000, 16'h5000, i[0], i[0], 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk(err_count == 8'd255, "err_saturate", err_count, 255);

    // Backpressure: one in flight plus four queued fills the FIFO
    n0 = rv_cnt;
    rr_dir = 1'b0;
    for (int i = 0; i < 5; i++)
      send(16'h3100 + 16'(i), 16'h6000 + 16'(i), 1'b1, 1'b0, 32'h0);
    chk(req_ready == 1'b0, "full_ready", req_ready, 0);
    set_req(16'h3105, 16'h6005, 1'b1, 1'b0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk(req_ready == 1'b0, "still_full", req_ready, 0);
    rr_dir = 1'b1;
    send(16'h3105, 16'h6005, 1'b1, 1'b0, 32'h0);
    drain(200);
    chk(rv_cnt - n0 == 6, "bp_resp_count", rv_cnt - n0, 6);

    // Reset during WAIT with three entries queued
    rr_dir = 1'b0;
    for (int i = 0; i < 5; i++)
      send(16'h3200 + 16'(i), 16'h6100 + 16'(i), 1'b1, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rr_dir = 1'b1;
    @(posedge clk); #1;
    rr_dir = 1'b0;
    t = 0;
    while (!mem_read && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(mem_read == 1'b1, "reset_pre_strobe", mem_read, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk({resp_valid, resp_read, resp_write, mem_read, mem_write, req_ready,
         err_count, cache_addr, cache_data_in, resp_data} == 0,
        "mid_rst_outputs",
        {resp_valid, resp_read, resp_write, mem_read, mem_write, req_ready,
         err_count, cache_addr, cache_data_in, resp_data}, 0);
    chk({resp_dest_addr, resp_src_addr} == 0, "mid_rst_addrs",
        {resp_dest_addr, resp_src_addr}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk(req_ready == 1'b1, "ready_after_mid_rst", req_ready, 1);
    rr_dir = 1'b1;
    n0 = rv_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk(rv_cnt == n0, "no_resp_after_rst", rv_cnt - n0, 0);

    // Randomized traffic with random backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int k;
      logic [15:0] d;
      k = $urandom_range(0, 9);
      d = {4'($urandom_range(0, 15)), 8'h00, 4'($urandom_range(0, 15))};
      if (k == 0) begin
        logic b;
        b = 1'($urandom);
        send(d, 16'($urandom), b, b, $urandom);
      end else begin
        send(d, 16'($urandom), k < 6, k >= 6, $urandom);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_bp = 1'b0;
    rr_dir = 1'b1;
    drain(1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
